mc_controller: RTL
==================

Name: mc_controller

Overview:
- Multicycle RISC-V control unit for the RV32I subset lw, sw, R-type ALU, I-type ALU, beq and jal.
- Sits directly upstream of the immediate extend unit. It decodes the latched instruction's opcode into immsrc and steps the datapath through the fetch/decode/execute/writeback sequence.
- It also generates every other datapath select and write enable, plus the ALU control code.

Parameters:
ILLEGAL_TRAP, 0, 0: an unknown opcode in DECODE returns to FETCH; 1: enter HALT and stay there until reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset
op  input  7  instr[6:0] from the instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag
immsrc  output  2  to extend unit: 00 I, 01 S, 10 B, 11 J
alusrca  output  2  00 PC, 01 OldPC, 10 rs1
alusrcb  output  2  00 rs2, 01 immext, 10 constant 4
resultsrc  output  2  00 ALUOut, 01 read data, 10 ALUResult
alucontrol  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
adrsrc  output  1  memory address: 0 PC, 1 result
irwrite  output  1  instruction register load
pcwrite  output  1  PC load
regwrite  output  1  register file write
memwrite  output  1  data memory write
illegal  output  1  unknown opcode seen in DECODE
state_o  output  4  current state (debug)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-low on rst_n.
- Reset:
  - rst_n=0 at a rising edge sets state to FETCH (0).
  - While rst_n=0, irwrite, pcwrite, regwrite, memwrite and illegal are forced to 0.
  - All other outputs follow the normal decode of the current state.
  - Reset mid-instruction aborts the instruction; no partial write occurs.
- Output timing: outputs are combinational (Moore) from state, except pcwrite (also uses zero), immsrc (from op only) and alucontrol (from aluop, op, funct3 and funct7b5).
- Unlisted outputs in a state are 0.
- immsrc decode from op:
  - 0000011, 0010011, 1100111 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - any other op -> 00
- States (state_o encoding), outputs, next state:
  - FETCH(0): adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=00, resultsrc=10, pcupdate=1 -> DECODE.
  - DECODE(1): alusrca=01, alusrcb=01, aluop=00. Next state by op:
    - lw/sw -> MEMADR(2)
    - 0110011 -> EXECUTER(6)
    - 0010011 -> EXECUTEI(7)
    - 1100011 -> BEQ(9)
    - 1101111 -> JAL(10)
    - any other op -> illegal=1, then FETCH (ILLEGAL_TRAP=0) or HALT(11) (ILLEGAL_TRAP=1).
  - MEMADR(2): alusrca=10, alusrcb=01, aluop=00 -> MEMREAD(3) if op=0000011, else MEMWRITE(5).
  - MEMREAD(3): resultsrc=00, adrsrc=1 -> MEMWB(4).
  - MEMWB(4): resultsrc=01, regwrite=1 -> FETCH.
  - MEMWRITE(5): resultsrc=00, adrsrc=1, memwrite=1 -> FETCH.
  - EXECUTER(6): alusrca=10, alusrcb=00, aluop=10 -> ALUWB(8).
  - EXECUTEI(7): alusrca=10, alusrcb=01, aluop=10 -> ALUWB(8).
  - ALUWB(8): resultsrc=00, regwrite=1 -> FETCH.
  - BEQ(9): alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1 -> FETCH.
  - JAL(10): alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1 -> ALUWB(8).
  - HALT(11): all enables 0; holds until rst_n=0.
  - Encodings 12-15 are unreachable; the next state is FETCH.
- pcwrite = pcupdate | (branch & zero), evaluated combinationally in the same cycle.
- ALU decode:
  - aluop 00 -> 000.
  - aluop 01 -> 001.
  - aluop 10, by funct3:
    - 000 -> 001 if (funct7b5 & op[5]), else 000
    - 010 -> 101
    - 110 -> 011
    - 111 -> 010
    - other funct3 -> 000
- Instruction latency in cycles: lw 5, sw 4, R/I 4, beq 3, jal 4.

Test Plan:
- Reset, then lw: op=0000011 -> state_o sequence 0,1,2,3,4,0; irwrite=1 only in state 0; regwrite=1 only in state 4; adrsrc=1 in state 3; immsrc=00.
- sw: op=0100011 -> sequence 0,1,2,5,0; memwrite=1 only in state 5; immsrc=01; regwrite never 1.
- beq: op=1100011 with zero=1 in state 9 -> pcwrite=1 and immsrc=10. Repeat with zero=0 -> pcwrite=0 in state 9. Both return to state 0.
- R/I decode:
  - op=0110011, funct3=000, funct7b5=1 -> alucontrol=001 in state 6.
  - op=0010011, funct3=000, funct7b5=1 -> alucontrol=000 in state 7.
  - funct3=111 -> alucontrol=010.
- jal: op=1101111 -> sequence 0,1,10,8,0; immsrc=11; pcwrite=1 in states 0 and 10; regwrite=1 in state 8.
- Reset and illegal:
  - rst_n=0 during state 3 -> state_o=0 after the edge; all write enables 0 while low.
  - op=0000000 with ILLEGAL_TRAP=0 -> illegal=1 in state 1, then state 0.
  - op=0000000 with ILLEGAL_TRAP=1 -> state 11 held for 10 cycles, exits only on reset.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle RV32I control unit (lw, sw, R/I ALU, beq, jal): Moore sequencer
// driving datapath selects and enables, plus immediate-type and ALU decode.
module mc_controller #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [2:0] alucontrol,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       illegal,
  output logic [3:0] state_o
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] aluop;
  logic       pcupdate, branch;
  logic       irw, regw, memw, ill;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    resultsrc = 2'b00;
    aluop     = 2'b00;
    adrsrc    = 1'b0;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    irw       = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    ill       = 1'b0;
    case (state_q)
      S_FETCH: begin
        irw       = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        pcupdate  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            ill     = 1'b1;
            state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regw      = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc = 1'b1;
        memw   = 1'b1;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: regw = 1'b1;
      S_BEQ: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      S_JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
        state_d  = S_ALUWB;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates every architectural write so an aborted instruction leaves no trace.
  assign irwrite  = irw  & rst_n;
  assign regwrite = regw & rst_n;
  assign memwrite = memw & rst_n;
  assign illegal  = ill  & rst_n;
  assign pcwrite  = (pcupdate | (branch & zero)) & rst_n;
  assign state_o  = state_q;

  always_comb begin
    case (op)
      OP_LW, OP_I, OP_JALR: immsrc = 2'b00;
      OP_SW:                immsrc = 2'b01;
      OP_BEQ:               immsrc = 2'b10;
      OP_JAL:               immsrc = 2'b11;
      default:              immsrc = 2'b00;
    endcase
  end

  // op[5] separates R-type sub from I-type addi, which has no sub form.
  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alucontrol = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

endmodule
